// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the access-control state machine and the memory access unit.
package mem_access_unit_pkg;

    localparam int unsigned ADDR_W_DEF = 4;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned CNT_W_DEF  = 8;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    // State encodings of the upstream state machine: bit 1 = valid, bit 0 = rw.
    typedef enum logic [1:0] {
        ST_IDLE   = {1'b0, RW_READ},
        ST_STABLE = {1'b0, RW_WRITE},
        ST_READ   = {1'b1, RW_READ},
        ST_WRITE  = {1'b1, RW_WRITE}
    } acc_state_e;

    // Reassemble the request lines into the state machine's encoding.
    function automatic acc_state_e req_state(input logic valid, input logic rw);
        return acc_state_e'({valid, rw});
    endfunction

endpackage

// File: rtl/mem_access_unit_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: advance only while below the saturation value.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: resettable register array, two-stage forwarded read
// pipeline, registered write acknowledge and saturating access counters.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              wr_ack,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    acc_state_e        req;
    logic              rd_en;
    logic              wr_en;
    logic              fwd_hit;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] s1_addr_q,     s1_addr_d;
    logic              s1_valid_q,    s1_valid_d;
    logic [DATA_W-1:0] rdata_q,       rdata_d;
    logic              rdata_valid_q, rdata_valid_d;
    logic              wr_ack_q,      wr_ack_d;

    // Decode the request and detect a same-edge write to the address in stage 1.
    always_comb begin
        req     = req_state(valid, rw);
        rd_en   = (req == ST_READ);
        wr_en   = (req == ST_WRITE);
        fwd_hit = wr_en && (addr == s1_addr_q);
    end

    // Pipeline next-state: stage 1 captures the read address, stage 2 loads
    // the array word, or the write data landing on the same edge.
    always_comb begin
        s1_addr_d     = s1_addr_q;
        s1_valid_d    = rd_en;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        wr_ack_d      = wr_en;
        if (rd_en) begin
            s1_addr_d = addr;
        end
        if (s1_valid_q) begin
            rdata_valid_d = 1'b1;
            rdata_d       = fwd_hit ? wdata : mem_q[s1_addr_q];
        end
    end

    // Register array; every word is cleared on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[addr] <= wdata;
        end
    end

    // Pipeline and strobe registers; reset drops any in-flight read.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_addr_q     <= '0;
            s1_valid_q    <= 1'b0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            wr_ack_q      <= 1'b0;
        end else begin
            s1_addr_q     <= s1_addr_d;
            s1_valid_q    <= s1_valid_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            wr_ack_q      <= wr_ack_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_rd_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (rd_en),
        .count (rd_count)
    );

    sat_counter #(.W(CNT_W)) u_wr_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (wr_en),
        .count (wr_count)
    );

    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign wr_ack      = wr_ack_q;

endmodule
